// File: rtl/sys_mem_pkg.sv
// rtl/sys_mem_pkg.sv - shared command/state types and burst lengths for the sys BRAM responder
package sys_mem_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WR256 = 2'b01,
    CMD_RD32  = 2'b10,
    CMD_RD256 = 2'b11
  } cmd_e;

  localparam int BURST_LONG  = 128;
  localparam int BURST_SHORT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_RD,
    ST_WR,
    ST_TURN,
    ST_REFRESH
  } state_e;

endpackage

// File: rtl/sys_bram.sv
// rtl/sys_bram.sv - single-port 16-bit BRAM with one-cycle registered read
module sys_bram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_sys_bram_responder.sv
// rtl/sdram_sys_bram_responder.sv - SDRAM sys-command responder backed by on-chip BRAM
module sdram_sys_bram_responder
  import sys_mem_pkg::*;
#(
  parameter int MEM_AW         = 14,
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [1:0]  sys_CMD,
  input  logic [22:0] sys_ADDR,
  input  logic [15:0] sys_DIN,
  output logic [15:0] sys_DOUT,
  output logic        sys_rd_data_valid,
  output logic        sys_wr_data_valid,
  output logic [1:0]  sys_cmd_ack
);

  localparam int CNT_MAX = (REFRESH_CYCLES > BURST_LONG) ? REFRESH_CYCLES : BURST_LONG;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  state_e            state, state_nxt;
  cmd_e              cmd_q;
  logic [MEM_AW-1:0] base_q;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     last_beat;
  logic [RW-1:0]     ref_cnt;
  logic              ref_pending;
  logic [MEM_AW-1:0] beat_addr;
  logic [MEM_AW-1:0] wr_addr_q;
  logic              wr_pend;
  logic              rd_valid;
  logic [15:0]       dout_hold;
  logic [15:0]       bram_rdata;

  assign last_beat = (cmd_q == CMD_RD32) ? CW'(BURST_SHORT - 1) : CW'(BURST_LONG - 1);
  assign beat_addr = base_q + MEM_AW'(cnt);

  always_comb begin
    state_nxt         = state;
    sys_cmd_ack       = 2'b00;
    sys_wr_data_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        // refresh wins over a waiting command
        if (ref_pending)             state_nxt = ST_REFRESH;
        else if (sys_CMD != 2'b00)   state_nxt = ST_ACK;
      end
      ST_ACK: begin
        sys_cmd_ack = cmd_q;
        state_nxt   = (cmd_q == CMD_WR256) ? ST_WR : ST_RD;
      end
      ST_RD: begin
        if (cnt == last_beat) state_nxt = ST_TURN;
      end
      ST_WR: begin
        sys_wr_data_valid = 1'b1;
        if (cnt == last_beat) state_nxt = ST_TURN;
      end
      ST_TURN:    state_nxt = ST_IDLE;
      ST_REFRESH: if (cnt == CW'(REFRESH_CYCLES - 1)) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cmd_q     <= CMD_NOP;
      base_q    <= '0;
      wr_pend   <= 1'b0;
      wr_addr_q <= '0;
      rd_valid  <= 1'b0;
      dout_hold <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
      if (state == ST_IDLE && state_nxt == ST_ACK) begin
        cmd_q  <= cmd_e'(sys_CMD);
        base_q <= MEM_AW'({sys_ADDR, 1'b0});
      end
      // write data trails its strobe by one cycle, so address is pipelined with it
      wr_pend   <= (state == ST_WR);
      wr_addr_q <= beat_addr;
      rd_valid  <= (state == ST_RD);
      if (rd_valid) dout_hold <= bram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else if (REFRESH_PERIOD != 0 && ref_cnt == RW'(REFRESH_PERIOD - 1)) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
      if (state == ST_IDLE && ref_pending) ref_pending <= 1'b0;
    end
  end

  sys_bram #(.AW(MEM_AW)) u_bram (
    .clk   (clk),
    .we    (wr_pend),
    .addr  (wr_pend ? wr_addr_q : beat_addr),
    .wdata (sys_DIN),
    .rdata (bram_rdata)
  );

  assign sys_rd_data_valid = rd_valid;
  assign sys_DOUT          = rd_valid ? bram_rdata : dout_hold;

endmodule

// File: tb/tb_sdram_sys_bram_responder.sv
// tb/tb_sdram_sys_bram_responder.sv - self-checking bench for the sys BRAM responder
module tb_sdram_sys_bram_responder;

  localparam int AW = 10;
  localparam int M  = 1 << AW;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [1:0]  sys_CMD;
  logic [22:0] sys_ADDR;
  logic [15:0] sys_DIN;
  logic [15:0] sys_DOUT;
  logic        sys_rd_data_valid;
  logic        sys_wr_data_valid;
  logic [1:0]  sys_cmd_ack;

  always #5 clk = ~clk;

  sdram_sys_bram_responder #(
    .MEM_AW(AW), .REFRESH_PERIOD(200), .REFRESH_CYCLES(8)
  ) dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .sys_CMD           (sys_CMD),
    .sys_ADDR          (sys_ADDR),
    .sys_DIN           (sys_DIN),
    .sys_DOUT          (sys_DOUT),
    .sys_rd_data_valid (sys_rd_data_valid),
    .sys_wr_data_valid (sys_wr_data_valid),
    .sys_cmd_ack       (sys_cmd_ack)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [22:0] addr;
    logic [15:0] first;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_ack_cyc;
  int          start_cyc;
  logic [15:0] model [M];
  bit          known [M];
  logic [15:0] wbuf  [128];
  vec_t        tbl   [7];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    sys_CMD = 2'b00;
    tick();
    tick();
    reset_i = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sys_cmd_ack != 2'b00) begin
        ok = 1'b1;
        last_ack_cyc = cyc;
        return;
      end
    end
  endtask

  // Issues one command from an IDLE cycle and checks the whole burst; ends on the next IDLE cycle.
  task automatic burst(input logic [1:0] cmd, input logic [22:0] addr,
                       input bit use_exp, input logic [15:0] exp_first);
    int n, base, werr, verr, w;
    bit ok;
    logic [15:0] exp, last_exp;
    bit last_known;
    n    = (cmd == 2'b10) ? 16 : 128;
    base = (int'(addr) * 2) % M;
    sys_CMD  = cmd;
    sys_ADDR = addr;
    start_cyc = cyc;
    wait_ack(ok);
    chk("ack_seen", 32'(ok), 32'd1);
    if (!ok) begin
      sys_CMD = 2'b00;
      return;
    end
    chk("ack_value", 32'(sys_cmd_ack), 32'(cmd));
    sys_CMD  = 2'b00;
    sys_ADDR = 23'($urandom);
    tick();
    chk("ack_one_cycle", 32'(sys_cmd_ack), 32'd0);
    if (cmd == 2'b01) begin
      werr = 0;
      for (int k = 0; k < n; k++) begin
        if (sys_wr_data_valid !== 1'b1 || sys_rd_data_valid !== 1'b0 || sys_cmd_ack !== 2'b00) werr++;
        if (k > 0) sys_DIN = wbuf[k-1];
        tick();
      end
      chk("wr_strobe_window_errs", 32'(werr), 32'd0);
      chk("wr_strobe_end", 32'(sys_wr_data_valid), 32'd0);
      sys_DIN = wbuf[n-1];
      tick();
      sys_DIN = 16'($urandom);
      for (int k = 0; k < n; k++) begin
        model[(base + k) % M] = wbuf[k];
        known[(base + k) % M] = 1'b1;
      end
    end else begin
      chk("rd_not_valid_at_t2", 32'(sys_rd_data_valid), 32'd0);
      tick();
      verr = 0;
      last_known = 1'b0;
      last_exp = '0;
      for (int k = 0; k < n; k++) begin
        w = (base + k) % M;
        if (sys_rd_data_valid !== 1'b1 || sys_cmd_ack !== 2'b00) verr++;
        exp = use_exp ? exp_first + 16'(k) : model[w];
        last_known = use_exp || known[w];
        last_exp = exp;
        if (last_known) chk("rd_beat", 32'(sys_DOUT), 32'(exp));
        tick();
      end
      chk("rd_valid_window_errs", 32'(verr), 32'd0);
      chk("rd_valid_end", 32'(sys_rd_data_valid), 32'd0);
      if (last_known) chk("dout_hold", 32'(sys_DOUT), 32'(last_exp));
    end
  endtask

  initial begin
    int ack_cyc [$];
    logic [1:0] ack_val [$];
    int vcnt [3];
    int beat;
    bit ok;
    logic [1:0] c;

    reset_i  = 1'b1;
    sys_CMD  = 2'b00;
    sys_ADDR = '0;
    sys_DIN  = '0;
    for (int i = 0; i < M; i++) known[i] = 1'b0;
    do_reset();

    chk("reset_dout", 32'(sys_DOUT), 32'd0);
    chk("reset_rd_valid", 32'(sys_rd_data_valid), 32'd0);
    chk("reset_wr_valid", 32'(sys_wr_data_valid), 32'd0);
    chk("reset_ack", 32'(sys_cmd_ack), 32'd0);

    tbl[0] = '{cmd: 2'b01, addr: 23'd0,   first: 16'h0000};
    tbl[1] = '{cmd: 2'b11, addr: 23'd0,   first: 16'h0000};
    tbl[2] = '{cmd: 2'b01, addr: 23'd0,   first: 16'h1000};
    tbl[3] = '{cmd: 2'b10, addr: 23'd16,  first: 16'h1020};
    tbl[4] = '{cmd: 2'b01, addr: 23'd480, first: 16'h2000};
    tbl[5] = '{cmd: 2'b11, addr: 23'd480, first: 16'h2000};
    tbl[6] = '{cmd: 2'b10, addr: 23'd0,   first: 16'h2040};
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 128; k++) wbuf[k] = tbl[v].first + 16'(k);
      burst(tbl[v].cmd, tbl[v].addr, 1'b1, tbl[v].first);
      if (v == 0) chk("first_ack_latency", 32'(last_ack_cyc - start_cyc), 32'd1);
    end

    for (int t = 0; t < 16; t++) begin
      c = 2'($urandom_range(1, 3));
      for (int k = 0; k < 128; k++) wbuf[k] = 16'($urandom);
      burst(c, 23'($urandom), 1'b0, 16'h0);
    end

    // reset lands while beat 50 is being strobed
    do_reset();
    sys_CMD  = 2'b01;
    sys_ADDR = 23'd0;
    wait_ack(ok);
    chk("rst_ack_seen", 32'(ok), 32'd1);
    chk("rst_ack_value", 32'(sys_cmd_ack), 32'd1);
    sys_CMD = 2'b00;
    tick();
    for (int k = 0; k < 50; k++) begin
      if (k > 0) sys_DIN = 16'hA000 + 16'(k - 1);
      tick();
    end
    sys_DIN = 16'hA000 + 16'd49;
    chk("rst_strobe_before", 32'(sys_wr_data_valid), 32'd1);
    reset_i = 1'b1;
    tick();
    chk("rst_wr_valid_after", 32'(sys_wr_data_valid), 32'd0);
    chk("rst_rd_valid_after", 32'(sys_rd_data_valid), 32'd0);
    chk("rst_ack_after", 32'(sys_cmd_ack), 32'd0);
    reset_i = 1'b0;
    cyc = 0;
    for (int k = 0; k < 49; k++) begin
      model[k] = 16'hA000 + 16'(k);
      known[k] = 1'b1;
    end
    known[49] = 1'b0;
    burst(2'b11, 23'd0, 1'b0, 16'h0);
    chk("rst_then_idle_ack_latency", 32'(last_ack_cyc - start_cyc), 32'd1);

    // held read command across a refresh expiry
    do_reset();
    sys_CMD  = 2'b11;
    sys_ADDR = 23'd0;
    vcnt = '{0, 0, 0};
    beat = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (sys_cmd_ack != 2'b00) begin
        ack_cyc.push_back(cyc);
        ack_val.push_back(sys_cmd_ack);
        beat = 0;
      end
      if (sys_rd_data_valid === 1'b1) begin
        if (ack_cyc.size() >= 1 && ack_cyc.size() <= 3) vcnt[ack_cyc.size() - 1]++;
        if (beat < 128 && known[beat]) chk("held_rd_beat", 32'(sys_DOUT), 32'(model[beat]));
        beat++;
      end
    end
    sys_CMD = 2'b00;
    chk("held_ack_count", 32'(ack_cyc.size()), 32'd3);
    if (ack_cyc.size() == 3) begin
      chk("held_ack0_cycle", 32'(ack_cyc[0]), 32'd1);
      chk("held_ack_sep", 32'(ack_cyc[1] - ack_cyc[0]), 32'd131);
      chk("held_refresh_sep", 32'(ack_cyc[2] - ack_cyc[1]), 32'd140);
      for (int i = 0; i < 3; i++) chk("held_ack_val", 32'(ack_val[i]), 32'd3);
      chk("held_burst0_beats", 32'(vcnt[0]), 32'd128);
      chk("held_burst1_beats", 32'(vcnt[1]), 32'd128);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
